// File: rtl/interrupt_ack_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_ack_sequencer
//
// Consumer side of the interrupt request register in an 8259-style PIC core.
// It masks the incoming IRR and applies fixed priority against the in-service
// register, with IR0 highest. It raises int_out to the CPU and runs the
// two-pulse INTA handshake. During the handshake it drives freeze and
// clear_IRR back into the request register, maintains the ISR, and presents
// the 8-bit vector during the second INTA pulse.
//
// Ports:
//   clk                         system clock
//   rst                         synchronous reset, active-low
//   interrupt_request_register  current IRR contents
//   interrupt_mask              IMR, 1 = masked
//   interrupt_vector_base       ICW2 T7..T3, upper five vector bits
//   auto_eoi_config             1 = automatic EOI at end of the second INTA
//   eoi_request                 one-cycle non-specific EOI pulse
//   inta_n                      CPU acknowledge, active-low, already synchronised
//   int_out                     interrupt request to the CPU
//   freeze                      holds the IRR steady during the acknowledge
//   clear_IRR                   one-cycle clear pulse for the acknowledged bit
//   in_service_register         ISR
//   vector_out                  interrupt vector
//   vector_out_en               vector valid / data-bus drive enable
// -----------------------------------------------------------------------------
module interrupt_ack_sequencer #(
    parameter int SPURIOUS_IRQ = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] interrupt_mask,
    input  logic [4:0] interrupt_vector_base,
    input  logic       auto_eoi_config,
    input  logic       eoi_request,
    input  logic       inta_n,
    output logic       int_out,
    output logic       freeze,
    output logic [7:0] clear_IRR,
    output logic [7:0] in_service_register,
    output logic [7:0] vector_out,
    output logic       vector_out_en
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_ACK1  = 3'd2,
        ST_WAIT2 = 3'd3,
        ST_ACK2  = 3'd4
    } state_t;

    // Isolates the lowest set bit as a one-hot value; zero stays zero.
    function automatic logic [7:0] lowest_onehot(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

    // Index of the lowest set bit; only meaningful when v is non-zero.
    function automatic logic [2:0] lowest_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = v[i] ? 3'(i) : idx;
        end
        return idx;
    endfunction

    // Requests must be strictly higher priority (lower index) than the
    // highest-priority interrupt currently in service.
    function automatic logic [7:0] priority_window(input logic [7:0] isr);
        logic [7:0] window;
        if (isr == 8'h00) begin
            window = 8'hFF;
        end else begin
            window = lowest_onehot(isr) - 8'd1;
        end
        return window;
    endfunction

    state_t     state_q, state_d;
    logic       int_out_q, int_out_d;
    logic       freeze_q, freeze_d;
    logic [7:0] clear_irr_q, clear_irr_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] vector_q, vector_d;
    logic       vector_en_q, vector_en_d;
    logic [2:0] idx_q, idx_d;
    logic       spurious_q, spurious_d;
    logic       inta_n_q, inta_n_d;

    logic [7:0] pending_s;
    logic [7:0] eligible_s;
    logic [2:0] winner_s;
    logic       inta_fall_s;
    logic       inta_rise_s;
    logic [7:0] isr_set_s;
    logic [7:0] isr_clr_s;

    // Request qualification and INTA edge detection.
    always_comb begin
        pending_s   = interrupt_request_register & ~interrupt_mask;
        eligible_s  = pending_s & priority_window(isr_q);
        winner_s    = lowest_index(eligible_s);
        inta_fall_s = inta_n_q & ~inta_n;
        inta_rise_s = ~inta_n_q & inta_n;
    end

    // Handshake FSM next-state, output and ISR update logic.
    always_comb begin
        state_d     = state_q;
        int_out_d   = int_out_q;
        freeze_d    = freeze_q;
        clear_irr_d = 8'h00;
        vector_d    = vector_q;
        vector_en_d = vector_en_q;
        idx_d       = idx_q;
        spurious_d  = spurious_q;
        inta_n_d    = inta_n;
        isr_set_s   = 8'h00;
        isr_clr_s   = 8'h00;

        // A non-specific EOI retires the highest-priority in-service level.
        if (eoi_request) begin
            isr_clr_s = lowest_onehot(isr_q);
        end else begin
            isr_clr_s = 8'h00;
        end

        case (state_q)
            ST_IDLE: begin
                int_out_d = (eligible_s != 8'h00);
                if (eligible_s != 8'h00) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // int_out stays up even if the request goes away; the CPU
                // has to be answered with a spurious vector in that case.
                if (inta_fall_s) begin
                    freeze_d  = 1'b1;
                    int_out_d = 1'b0;
                    state_d   = ST_ACK1;
                    if (eligible_s != 8'h00) begin
                        idx_d       = winner_s;
                        spurious_d  = 1'b0;
                        isr_set_s   = 8'd1 << winner_s;
                        clear_irr_d = 8'd1 << winner_s;
                    end else begin
                        idx_d      = 3'(SPURIOUS_IRQ);
                        spurious_d = 1'b1;
                    end
                end else begin
                    int_out_d = 1'b1;
                end
            end
            ST_ACK1: begin
                if (inta_rise_s) begin
                    state_d = ST_WAIT2;
                end else begin
                    state_d = ST_ACK1;
                end
            end
            ST_WAIT2: begin
                if (inta_fall_s) begin
                    state_d     = ST_ACK2;
                    vector_d    = {interrupt_vector_base, idx_q};
                    vector_en_d = 1'b1;
                end else begin
                    state_d = ST_WAIT2;
                end
            end
            ST_ACK2: begin
                if (inta_rise_s) begin
                    state_d     = ST_IDLE;
                    vector_en_d = 1'b0;
                    freeze_d    = 1'b0;
                    if (auto_eoi_config && !spurious_q) begin
                        isr_clr_s = isr_clr_s | (8'd1 << idx_q);
                    end else begin
                        isr_clr_s = isr_clr_s;
                    end
                end else begin
                    state_d = ST_ACK2;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                int_out_d   = 1'b0;
                freeze_d    = 1'b0;
                vector_en_d = 1'b0;
            end
        endcase

        // Set is applied after the clear so that a coincident set wins.
        isr_d = (isr_q & ~isr_clr_s) | isr_set_s;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            int_out_q   <= 1'b0;
            freeze_q    <= 1'b0;
            clear_irr_q <= 8'h00;
            isr_q       <= 8'h00;
            vector_q    <= 8'h00;
            vector_en_q <= 1'b0;
            idx_q       <= 3'd0;
            spurious_q  <= 1'b0;
            inta_n_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            int_out_q   <= int_out_d;
            freeze_q    <= freeze_d;
            clear_irr_q <= clear_irr_d;
            isr_q       <= isr_d;
            vector_q    <= vector_d;
            vector_en_q <= vector_en_d;
            idx_q       <= idx_d;
            spurious_q  <= spurious_d;
            inta_n_q    <= inta_n_d;
        end
    end

    assign int_out             = int_out_q;
    assign freeze              = freeze_q;
    assign clear_IRR           = clear_irr_q;
    assign in_service_register = isr_q;
    assign vector_out          = vector_q;
    assign vector_out_en       = vector_en_q;

endmodule

// File: doc/interrupt_ack_sequencer.md
Name: interrupt_ack_sequencer

Overview:
- Consumer side of the interrupt request register in the 8259 PIC core.
- Reads the IRR, applies the mask and in-service priority, raises INT to the CPU, and runs the two-pulse INTA handshake.
- Drives freeze and clear_IRR back into the request register, maintains the in-service register (ISR), and supplies the 8-bit vector on the second INTA.

Parameters:
- SPURIOUS_IRQ, 7, IR index reported (vector low bits) when no request is eligible at the first INTA.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-low
- interrupt_request_register  input  8  current IRR contents
- interrupt_mask  input  8  IMR; 1 = masked
- interrupt_vector_base  input  5  ICW2 T7..T3
- auto_eoi_config  input  1  1 = AEOI mode
- eoi_request  input  1  one-cycle pulse, non-specific EOI
- inta_n  input  1  CPU interrupt acknowledge, active-low, already synchronised to clk
- int_out  output  1  interrupt request to CPU
- freeze  output  1  holds IRR during acknowledge
- clear_IRR  output  8  one-cycle clear pulse for the acknowledged bit
- in_service_register  output  8  ISR
- vector_out  output  8  interrupt vector
- vector_out_en  output  1  vector valid / data-bus drive enable

Behaviour:
- Reset (rst=0 sampled at a clk edge):
  - State IDLE.
  - int_out, freeze, vector_out_en = 0; clear_IRR, in_service_register, vector_out = 0.
  - Internal inta_n_d = 1.
  - Applies mid-handshake as well; no pending ack survives reset.
- Priority: fixed, IR0 highest.
  - pending = IRR & ~IMR.
  - eligible = pending bits with index strictly lower than the lowest set ISR bit (all pending bits if ISR = 0).
  - winner = lowest eligible index.
- INTA edges: falling = inta_n_d & ~inta_n; rising = ~inta_n_d & inta_n. inta_n_d registers inta_n every cycle.
- FSM:
  - IDLE: eligible != 0 at cycle N -> REQ, int_out = 1 from N+1 (one-cycle latency).
  - REQ: int_out held, even if the request is withdrawn.
    - On falling edge: freeze = 1; latch idx = winner.
    - If no eligible request, idx = SPURIOUS_IRQ and no ISR/IRR update.
    - Otherwise set ISR[idx] and pulse clear_IRR[idx] for exactly one cycle.
    - int_out = 0. Next state ACK1.
  - ACK1: rising edge -> WAIT2.
  - WAIT2: falling edge -> ACK2; vector_out = {interrupt_vector_base, idx}; vector_out_en = 1 in the same registered update.
  - ACK2: vector_out_en held while inta_n low. On rising edge:
    - vector_out_en = 0, freeze = 0, state IDLE.
    - If auto_eoi_config = 1 and the ack was not spurious, clear ISR[idx] on that edge.
    - vector_out holds its last value.
- EOI: eoi_request clears the lowest-index set ISR bit, evaluated on the ISR value at the start of the cycle. It is ignored when ISR = 0.
  - A same-cycle ISR set (REQ falling edge) and EOI clear both apply.
  - If they target the same bit, the set wins.
- freeze is high from the first INTA falling edge through the second INTA rising edge inclusive.
- INTA edges outside REQ/ACK1/WAIT2/ACK2 are ignored. A falling edge in IDLE starts no handshake.
- A new request while not in IDLE only raises int_out after returning to IDLE, with one-cycle latency.

Test Plan:
- Reset: hold rst=0 two cycles with IRR=0xFF -> all outputs 0, state IDLE; release, IMR=0xFF -> int_out stays 0.
- Single ack, base=5'b00001, IRR=0x04, IMR=0:
  - int_out=1 one cycle after IRR.
  - First INTA low -> clear_IRR=0x04 for one cycle, ISR=0x04, freeze=1.
  - Second INTA low -> vector_out=0x0A, vector_out_en=1.
  - INTA high -> freeze=0, vector_out_en=0.
- Priority/nesting:
  - With ISR=0x04, IRR=0x09 -> ack selects IR0, ISR=0x05.
  - EOI pulse -> ISR=0x04.
  - With IRR=0x08 only and ISR=0x04 -> int_out stays 0.
- Spurious: IRR=0x02 raises int_out; IRR drops to 0 before first INTA -> vector_out={base,3'b111}, clear_IRR=0, ISR unchanged.
- AEOI: auto_eoi_config=1, IRR=0x80 -> ISR=0x80 after first INTA; ISR returns to 0x00 at second INTA rising edge.
- Reset mid-handshake: rst=0 while in WAIT2 -> next cycle freeze=0, ISR=0, int_out=0; a subsequent INTA pulse produces no vector_out_en.
